// File: rtl/t_toggle_pkg.sv
// Shared constants and helpers for the toggle-event receiver.
// Holds the FSM encoding, the legal synchroniser depths and the queue-depth helper.
package t_toggle_pkg;

  localparam logic [0:0] ST_ARM = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic int pend_max(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction

  // Out-of-range depths are pulled back into the legal window instead of failing elaboration.
  function automatic int sync_clamp(input int stages);
    if (stages < SYNC_STAGES_MIN) begin
      return SYNC_STAGES_MIN;
    end else if (stages > SYNC_STAGES_MAX) begin
      return SYNC_STAGES_MAX;
    end else begin
      return stages;
    end
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop level synchroniser bringing the asynchronous toggle level into clk.
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s_q;
  logic [STAGES-1:0] s_d;

  // Shift the raw level one stage deeper each cycle.
  always_comb begin
    s_d = {s_q[STAGES-2:0], d};
  end

  // Chain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= {STAGES{1'b0}};
    end else begin
      s_q <= s_d;
    end
  end

  assign q = s_q[STAGES-1];

endmodule

// File: rtl/t_toggle_rx.sv
// Receive end of a toggle-event link: detects each level change of t_in, queues it,
// hands events out on a valid/ready port and acknowledges each one by flipping ack_t.
module t_toggle_rx
  import t_toggle_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t_in,
  input  logic             en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             ack_t,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int                SYNC_N   = sync_clamp(SYNC_STAGES);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(pend_max(PEND_W));
  localparam logic [2:0]        ARM_LAST = 3'(SYNC_N);

  logic              t_s;
  logic              t_prev_q,  t_prev_d;
  logic [0:0]        state_q,   state_d;
  logic [2:0]        arm_cnt_q, arm_cnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              ack_t_q,   ack_t_d;
  logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
  logic              ovf_q,     ovf_d;

  logic edge_det;
  logic pop;
  logic full_blk;
  logic acc;
  logic drop;

  toggle_sync #(
    .STAGES (SYNC_N)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (t_in),
    .q     (t_s)
  );

  assign evt_valid = (pending_q != {PEND_W{1'b0}});
  assign ack_t     = ack_t_q;
  assign evt_cnt   = evt_cnt_q;
  assign ovf       = ovf_q;

  // Edge detect and accept/drop decision; a pop in the same cycle frees a slot when full.
  always_comb begin
    t_prev_d = t_s;
    edge_det = t_s ^ t_prev_q;
    pop      = evt_valid & evt_ready;
    full_blk = (pending_q == PEND_MAX) & ~pop;
    if (state_q == ST_RUN) begin
      acc  = edge_det & en & ~full_blk;
      drop = edge_det & en & full_blk;
    end else begin
      acc  = 1'b0;
      drop = 1'b0;
    end
  end

  // ARM waits out the synchroniser flush so the t_in level at reset release is not an event.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      ST_ARM: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_d = ST_RUN;
        end else begin
          arm_cnt_d = arm_cnt_q + 3'd1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d   = ST_ARM;
        arm_cnt_d = 3'd0;
      end
    endcase
  end

  // Pending queue depth, acknowledge toggle, accepted count and sticky overflow.
  always_comb begin
    case ({acc, pop})
      2'b10:   pending_d = pending_q + {{(PEND_W-1){1'b0}}, 1'b1};
      2'b01:   pending_d = pending_q - {{(PEND_W-1){1'b0}}, 1'b1};
      default: pending_d = pending_q;
    endcase
    ack_t_d   = ack_t_q ^ pop;
    evt_cnt_d = evt_cnt_q + {{(CNT_W-1){1'b0}}, acc};
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_prev_q  <= 1'b0;
      state_q   <= ST_ARM;
      arm_cnt_q <= 3'd0;
      pending_q <= {PEND_W{1'b0}};
      ack_t_q   <= 1'b0;
      evt_cnt_q <= {CNT_W{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      t_prev_q  <= t_prev_d;
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      pending_q <= pending_d;
      ack_t_q   <= ack_t_d;
      evt_cnt_q <= evt_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_t_toggle_rx.sv
// Directed bench for t_toggle_rx: accepted toggles are queued as event serials and each
// observed pop is matched against the queue, with ack_t checked against the serial's parity.
module tb_t_toggle_rx;

  logic       clk;
  logic       rst_n;
  logic       t_in;
  logic       en;
  logic       evt_valid;
  logic       evt_ready;
  logic       ack_t;
  logic [7:0] evt_cnt;
  logic       ovf;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int serial   = 0;
  int sb[$];

  t_toggle_rx #(
    .SYNC_STAGES (2),
    .PEND_W      (2),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .t_in      (t_in),
    .en        (en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .ack_t     (ack_t),
    .evt_cnt   (evt_cnt),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; a handshake seen before the edge consumes the oldest queued serial.
  task automatic tick();
    logic pop_seen;
    int   exp_serial;
    @(negedge clk);
    pop_seen = evt_valid && evt_ready;
    @(posedge clk);
    #1;
    if (pop_seen) begin
      pops++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_serial = sb.pop_front();
        check("ack_t_on_pop", 32'(ack_t), 32'(exp_serial[0]));
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic toggle(input bit accept);
    t_in = ~t_in;
    if (accept) begin
      serial++;
      sb.push_back(serial);
    end
  endtask

  task automatic reset_and_arm();
    rst_n = 1'b0;
    t_in  = 1'b1;
    ticks(3);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_ack", 32'(ack_t), 32'd0);
    check("rst_cnt", 32'(evt_cnt), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("arm_no_event", 32'(evt_valid), 32'd0);
    end
    check("arm_cnt", 32'(evt_cnt), 32'd0);
    check("arm_ack", 32'(ack_t), 32'd0);
  endtask

  initial begin
    int p0;
    rst_n     = 1'b0;
    t_in      = 1'b1;
    en        = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Scenario 1: t_in held high across reset release gives no event.
    reset_and_arm();

    // Scenario 2: single toggle, valid after the third edge for exactly one cycle.
    evt_ready = 1'b1;
    toggle(1'b1);
    tick();
    check("lat_e1", 32'(evt_valid), 32'd0);
    tick();
    check("lat_e2", 32'(evt_valid), 32'd0);
    tick();
    check("lat_e3", 32'(evt_valid), 32'd1);
    check("cnt_after_1", 32'(evt_cnt), 32'd1);
    tick();
    check("valid_one_cycle", 32'(evt_valid), 32'd0);
    check("ack_after_1", 32'(ack_t), 32'd1);

    // Scenario 3: four toggles with no consumer, the fourth overflows.
    evt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      toggle(k < 3);
      ticks(4);
    end
    check("full_valid", 32'(evt_valid), 32'd1);
    check("full_ovf", 32'(ovf), 32'd1);
    check("full_cnt", 32'(evt_cnt), 32'd4);
    p0 = pops;
    evt_ready = 1'b1;
    ticks(5);
    check("drain_pops", 32'(pops - p0), 32'd3);
    check("drain_valid", 32'(evt_valid), 32'd0);
    check("drain_ack", 32'(ack_t), 32'd0);
    evt_ready = 1'b0;

    // Scenario 4: push and pop together while full, then clear colliding with a drop.
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
    for (int k = 0; k < 3; k++) begin
      toggle(1'b1);
      ticks(4);
    end
    toggle(1'b1);
    ticks(2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("pushpop_ovf", 32'(ovf), 32'd0);
    check("pushpop_cnt", 32'(evt_cnt), 32'd8);
    check("pushpop_valid", 32'(evt_valid), 32'd1);
    toggle(1'b0);
    ticks(2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("set_beats_clr", 32'(ovf), 32'd1);
    check("drop_not_counted", 32'(evt_cnt), 32'd8);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr_alone", 32'(ovf), 32'd0);
    p0 = pops;
    evt_ready = 1'b1;
    ticks(5);
    check("pending_was_3", 32'(pops - p0), 32'd3);
    check("drain2_valid", 32'(evt_valid), 32'd0);

    // Scenario 5: toggles with en low are ignored and leave no stale edge behind.
    en = 1'b0;
    toggle(1'b0);
    ticks(4);
    toggle(1'b0);
    ticks(4);
    check("en0_valid", 32'(evt_valid), 32'd0);
    check("en0_cnt", 32'(evt_cnt), 32'd8);
    check("en0_ovf", 32'(ovf), 32'd0);
    en = 1'b1;
    ticks(6);
    check("en1_no_spurious", 32'(evt_valid), 32'd0);
    check("en1_cnt", 32'(evt_cnt), 32'd8);

    // Scenario 6: asynchronous reset with events pending.
    evt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      toggle(1'b1);
      ticks(4);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    tick();
    check("pre_rst_valid", 32'(evt_valid), 32'd1);
    check("pre_rst_ack", 32'(ack_t), 32'd1);
    check("pre_rst_cnt", 32'(evt_cnt), 32'd11);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(evt_valid), 32'd0);
    check("async_rst_ack", 32'(ack_t), 32'd0);
    check("async_rst_cnt", 32'(evt_cnt), 32'd0);
    sb.delete();
    serial = 0;
    reset_and_arm();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
